// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and load/store.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (load/store always wins ties; default is round-robin).
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arstn,

  input  logic                  i_instr_req,
  input  logic [ADDR_WIDTH-1:0] i_instr_addr,
  output logic                  o_instr_gnt,
  output logic                  o_instr_done,
  output logic [DATA_WIDTH-1:0] o_instr_data,

  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_gnt,
  output logic                  o_data_done,
  output logic [DATA_WIDTH-1:0] o_data_rdata,

  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic PortInstr = 1'b0;
  localparam logic PortData  = 1'b1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  // Port id of the latched access; doubles as the round-robin last_owner flag since both
  // update to the granted port at every transfer edge.
  logic                  owner_q;

  logic instr_win;
  logic data_win;
  logic transfer;

  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (i_instr_req && i_data_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      data_win = 1'b1;
`else
      if (owner_q == PortInstr) begin
        data_win = 1'b1;
      end else begin
        instr_win = 1'b1;
      end
`endif
    end else if (i_data_req) begin
      data_win = 1'b1;
    end else if (i_instr_req) begin
      instr_win = 1'b1;
    end
  end

  assign transfer = instr_win | data_win;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= PortInstr;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        addr_q  <= data_win ? i_data_addr : i_instr_addr;
        wdata_q <= data_win ? i_data_wdata : wdata_q;
        we_q    <= data_win & i_data_we;
        owner_q <= data_win ? PortData : PortInstr;
      end
    end
  end

  always_comb begin
    state_d          = StIdle;
    o_instr_gnt      = 1'b0;
    o_data_gnt       = 1'b0;
    o_instr_done     = 1'b0;
    o_data_done      = 1'b0;
    o_instr_data     = '0;
    o_data_rdata     = '0;
    o_mem_write_en   = 1'b0;
    o_mem_addr       = addr_q;
    o_mem_write_data = wdata_q;

    // Grants are combinational, so reset must suppress them directly.
    o_instr_gnt = arstn & instr_win;
    o_data_gnt  = arstn & data_win;

    if (transfer) begin
      state_d = StAccess;
    end

    unique case (state_q)
      StIdle: begin
      end
      StAccess: begin
        o_mem_write_en = we_q;
        if (owner_q == PortData) begin
          o_data_done  = 1'b1;
          o_data_rdata = i_mem_read_data;
        end else begin
          o_instr_done = 1'b1;
          o_instr_data = i_mem_read_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word-addressed memory.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 64;

  logic          clk;
  logic          arstn;
  logic          i_instr_req;
  logic [AW-1:0] i_instr_addr;
  logic          o_instr_gnt;
  logic          o_instr_done;
  logic [DW-1:0] o_instr_data;
  logic          i_data_req;
  logic          i_data_we;
  logic [AW-1:0] i_data_addr;
  logic [DW-1:0] i_data_wdata;
  logic          o_data_gnt;
  logic          o_data_done;
  logic [DW-1:0] o_data_rdata;
  logic          o_mem_write_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_write_data;
  logic [DW-1:0] i_mem_read_data;

  logic [DW-1:0] mem [64];

  int checks;
  int errors;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .arstn           (arstn),
    .i_instr_req     (i_instr_req),
    .i_instr_addr    (i_instr_addr),
    .o_instr_gnt     (o_instr_gnt),
    .o_instr_done    (o_instr_done),
    .o_instr_data    (o_instr_data),
    .i_data_req      (i_data_req),
    .i_data_we       (i_data_we),
    .i_data_addr     (i_data_addr),
    .i_data_wdata    (i_data_wdata),
    .o_data_gnt      (o_data_gnt),
    .o_data_done     (o_data_done),
    .o_data_rdata    (o_data_rdata),
    .o_mem_write_en  (o_mem_write_en),
    .o_mem_addr      (o_mem_addr),
    .o_mem_write_data(o_mem_write_data),
    .i_mem_read_data (i_mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_mem_read_data = mem[o_mem_addr[7:2]];

  always @(posedge clk) begin
    if (o_mem_write_en) mem[o_mem_addr[7:2]] <= o_mem_write_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_instr_req  = 1'b0;
    i_data_req   = 1'b0;
    i_data_we    = 1'b0;
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[3] = 32'hDEAD_BEEF;
    mem[8] = 32'h0BAD_F00D;

    arstn        = 1'b0;
    i_instr_req  = 1'b1;
    i_instr_addr = 64'h0C;
    i_data_req   = 1'b0;
    i_data_we    = 1'b0;
    i_data_addr  = '0;
    i_data_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr_gnt", o_instr_gnt, 0);
    chk("rst_data_gnt", o_data_gnt, 0);
    chk("rst_done", {o_instr_done, o_data_done}, 0);
    chk("rst_we", o_mem_write_en, 0);
    chk("rst_addr", o_mem_addr, 0);

    // Fetch of mem[3] granted in the first cycle out of reset
    @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("fetch_gnt", {o_instr_gnt, o_data_gnt}, 2'b10);

    // Done cycle of fetch; store to 0x10 requested and granted during ACCESS
    @(negedge clk);
    i_instr_req  = 1'b0;
    i_data_req   = 1'b1;
    i_data_we    = 1'b1;
    i_data_addr  = 64'h10;
    i_data_wdata = 32'h1234_5678;
    #1;
    chk("fetch_done", o_instr_done, 1);
    chk("fetch_data", o_instr_data, 32'hDEAD_BEEF);
    chk("fetch_we", o_mem_write_en, 0);
    chk("store_gnt", {o_instr_gnt, o_data_gnt}, 2'b01);

    // Store cycle; back-to-back load of 0x10
    @(negedge clk);
    i_data_we    = 1'b0;
    i_data_wdata = 32'hFFFF_FFFF;
    #1;
    chk("store_we", o_mem_write_en, 1);
    chk("store_addr", o_mem_addr, 64'h10);
    chk("store_wdata", o_mem_write_data, 32'h1234_5678);
    chk("store_done", {o_instr_done, o_data_done}, 2'b01);
    chk("load_gnt", o_data_gnt, 1);

    @(negedge clk);
    idle_inputs();
    #1;
    chk("load_done", o_data_done, 1);
    chk("load_rdata", o_data_rdata, 32'h1234_5678);
    chk("load_we", o_mem_write_en, 0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_done", {o_instr_done, o_data_done}, 0);
      chk("idle_we", o_mem_write_en, 0);
      chk("idle_addr_hold", o_mem_addr, 64'h10);
    end

    // Contention from a fresh reset: both ports request continuously
    @(negedge clk);
    arstn = 1'b0;
    @(negedge clk);
    arstn        = 1'b1;
    i_instr_req  = 1'b1;
    i_instr_addr = 64'h0C;
    i_data_req   = 1'b1;
    i_data_we    = 1'b0;
    i_data_addr  = 64'h10;
    prev_d       = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_d = 1'b1;
`else
      exp_d = (k % 2 == 0);
`endif
      chk("tie_gnt", {o_instr_gnt, o_data_gnt}, exp_d ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("tie_done", {o_instr_done, o_data_done}, prev_d ? 2'b01 : 2'b10);
        chk("tie_rdata", prev_d ? o_data_rdata : o_instr_data,
            prev_d ? 32'h1234_5678 : 32'hDEAD_BEEF);
      end else begin
        chk("tie_first_done", {o_instr_done, o_data_done}, 0);
      end
      prev_d = exp_d;
      @(negedge clk);
    end
    i_data_req = 1'b0;
    #1;
    chk("drop_instr_gnt", {o_instr_gnt, o_data_gnt}, 2'b10);
    chk("drop_done", {o_instr_done, o_data_done}, prev_d ? 2'b01 : 2'b10);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drop_fetch_done", {o_instr_done, o_data_done}, 2'b10);
    chk("drop_fetch_data", o_instr_data, 32'hDEAD_BEEF);

    // Store to 0x20 aborted by reset while in ACCESS
    @(negedge clk);
    i_data_req   = 1'b1;
    i_data_we    = 1'b1;
    i_data_addr  = 64'h20;
    i_data_wdata = 32'hA5A5_A5A5;
    #1;
    chk("abort_gnt", o_data_gnt, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("abort_we_pre", o_mem_write_en, 1);
    arstn = 1'b0;
    #1;
    chk("abort_we", o_mem_write_en, 0);
    chk("abort_done", {o_instr_done, o_data_done}, 0);
    chk("abort_addr", o_mem_addr, 0);
    chk("abort_wdata", o_mem_write_data, 0);
    @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("abort_mem8", mem[8], 32'h0BAD_F00D);
    chk("abort_no_done", {o_instr_done, o_data_done}, 0);
    @(negedge clk);
    #1;
    chk("abort_idle", {o_instr_done, o_data_done, o_mem_write_en}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, memory word width; ADDR_WIDTH, 64, byte-address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 arstn  input  1  reset, asynchronous, active-low.
REQ-004 i_instr_req  input  1  instruction-fetch read request.
REQ-005 i_instr_addr  input  ADDR_WIDTH  fetch byte address.
REQ-006 o_instr_gnt  output  1  fetch request accepted at this edge.
REQ-007 o_instr_done  output  1  fetch data valid this cycle.
REQ-008 o_instr_data  output  DATA_WIDTH  fetch read data.
REQ-009 i_data_req, i_data_we  input  1 each  load/store request; write enable.
REQ-010 i_data_addr  input  ADDR_WIDTH; i_data_wdata  input  DATA_WIDTH  load/store address and store data.
REQ-011 o_data_gnt, o_data_done  output  1 each; o_data_rdata  output  DATA_WIDTH  load/store accept, completion, load data.
REQ-012 o_mem_write_en  output  1; o_mem_addr  output  ADDR_WIDTH; o_mem_write_data  output  DATA_WIDTH; i_mem_read_data  input  DATA_WIDTH  single-port memory side (combinational read, write at clock edge).

Function
REQ-013 Arbitration SHALL share one single-port memory between the fetch port (read-only) and the load/store port.
REQ-014 A request SHALL transfer at the rising edge where req and gnt are both high; the requester holds addr/wdata/we stable while req is high and gnt is low.
REQ-015 Grants SHALL be combinational, one-hot or zero, and issued in every cycle (IDLE or ACCESS) where at least one req is high.
REQ-016 Winning request's addr, wdata, we and port id SHALL be latched at the transfer edge.
REQ-017 FSM states: IDLE (no access in flight) and ACCESS (latched access driven to memory); any transfer -> ACCESS, else -> IDLE.
REQ-018 In ACCESS: o_mem_addr/o_mem_write_data = latched values, o_mem_write_en = latched we; done of the latched port = 1; its rdata = i_mem_read_data.
REQ-019 In IDLE: o_mem_write_en = 0, both done = 0; o_mem_addr/o_mem_write_data hold latched values.
REQ-020 Latency: transfer at edge N -> done high in cycle N+1; throughput one access per cycle (back-to-back ACCESS permitted).
REQ-021 Store completion SHALL assert o_data_done; o_data_rdata is don't-care for stores.
REQ-022 Simultaneous requests SHALL be resolved per REQ-027/REQ-028; the losing port keeps gnt low and is served no later than the next cycle under round-robin.
REQ-023 Owner flag last_owner SHALL update to the granted port at every transfer edge.

Reset
REQ-024 arstn low SHALL immediately force: state IDLE, all gnt/done = 0, o_mem_write_en = 0, latched addr/wdata/we = 0, last_owner = INSTR.
REQ-025 Reset during ACCESS SHALL abort the access; an in-flight store is not written and no done is produced after reset release.
REQ-026 First request after reset release SHALL be grantable in the first cycle with arstn high.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN defined: load/store port SHALL always win simultaneous requests (fetch can starve).
REQ-028 Macro undefined: round-robin; on a tie the port that is not last_owner wins.

Verification
REQ-029 mem[3]=0xDEADBEEF; fetch req addr 0x0C in IDLE -> o_instr_gnt=1 same cycle; next cycle o_instr_done=1, o_instr_data=0xDEADBEEF, o_mem_write_en=0.
REQ-030 Store addr 0x10 data 0x12345678, then load addr 0x10 back-to-back -> cycle N+1 o_mem_write_en=1, o_mem_addr=0x10; cycle N+2 o_data_done=1, o_data_rdata=0x12345678.
REQ-031 Round-robin build, both req held high 6 cycles from reset -> grants D,I,D,I,D,I; done pulses follow one cycle later, one per cycle.
REQ-032 MEM_ARB_FIXED_PRIO_EN build, both req held 4 cycles -> o_data_gnt=1 all 4 cycles, o_instr_gnt=0; fetch granted first cycle data req drops.
REQ-033 Store 0xA5A5A5A5 to 0x20 accepted, arstn pulled low mid-ACCESS before edge -> mem[8] unchanged, all outputs 0, state IDLE.
REQ-034 No req for 3 cycles after an access -> state IDLE, o_mem_write_en=0, both done=0.
